// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop/lap FSM, tick prescaler and carry-enable chain driving four
// external cascaded BCD digit counters, with lap capture, display mux and sticky wrap flag.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic        clk,
  input  logic        Clear_n,
  input  logic        btn_ss,
  input  logic        btn_lap,
  input  logic [3:0]  bcd0,
  input  logic [3:0]  bcd1,
  input  logic [3:0]  bcd2,
  input  logic [3:0]  bcd3,
  output logic [3:0]  dig_en,
  output logic        dig_clr_n,
  output logic [15:0] disp,
  output logic        running,
  output logic        ovf
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMax = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StLap} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   lap_q, lap_d;
  logic          clr_n_q, clr_n_d;

  logic [15:0]   bcd_all;
  logic          cnt_active;
  logic          tick;

  assign bcd_all    = {bcd3, bcd2, bcd1, bcd0};
  assign cnt_active = (state_q == StRun) || (state_q == StLap);
  assign tick       = cnt_active && (presc_q == PMax);

  // btn_ss always wins; a simultaneous btn_lap is dropped (no capture, no clear).
  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    clr_n_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (btn_ss) state_d = StRun;
      end
      StRun: begin
        if (btn_ss) begin
          state_d = StPause;
        end else if (btn_lap) begin
          state_d = StLap;
          lap_d   = bcd_all;
        end
      end
      StLap: begin
        if (btn_ss)       state_d = StPause;
        else if (btn_lap) state_d = StRun;
      end
      StPause: begin
        if (btn_ss) begin
          state_d = StRun;
        end else if (btn_lap) begin
          state_d = StIdle;
          clr_n_d = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    presc_d = presc_q;
    if ((state_q == StIdle) || !clr_n_d) begin
      presc_d = '0;
    end else if (cnt_active) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  always_comb begin
    dig_en    = 4'b0000;
    dig_en[0] = tick;
    dig_en[1] = dig_en[0] && (bcd0 == 4'd9);
    dig_en[2] = dig_en[1] && (bcd1 == 4'd9);
    dig_en[3] = dig_en[2] && (bcd2 == 4'd9);
  end

  // Clearing only happens from PAUSE, where no tick can occur, so set and clear never collide.
  always_comb begin
    ovf_d = ovf_q;
    if (!clr_n_d) begin
      ovf_d = 1'b0;
    end else if (dig_en[3] && (bcd3 == 4'd9)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q <= StIdle;
      presc_q <= '0;
      ovf_q   <= 1'b0;
      lap_q   <= 16'h0000;
      clr_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ovf_q   <= ovf_d;
      lap_q   <= lap_d;
      clr_n_q <= clr_n_d;
    end
  end

  assign dig_clr_n = clr_n_q;
  assign disp      = (state_q == StLap) ? lap_q : bcd_all;
  assign running   = cnt_active;
  assign ovf       = ovf_q;

endmodule
